// File: rtl/cadder_operand_sequencer.sv
// Operand collector and result returner for the 8-operand combinational adder.
// Gathers N beats into slots, lets the external adder settle, then offers its sum.
module cadder_operand_sequencer #(
   parameter int W      = 8,
   parameter int N      = 8,
   parameter int SETTLE = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   output logic [N*W-1:0] add_opnd,
   input  logic [W-1:0]   add_sum,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_sum,
   output logic           busy
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_HOLD} state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [SW-1:0]         set_q, set_d;
   logic [W-1:0]          sum_q, sum_d;
   logic [N-1:0][W-1:0]   opnd_q;

   logic accept, deliver, last_beat, settle_done;

   assign accept      = in_valid & in_ready;
   assign deliver     = out_valid & out_ready;
   assign last_beat   = (cnt_q == CW'(N - 1));
   assign settle_done = (set_q == '0);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_LOAD;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD:   if (accept && last_beat) state_d = ST_SETTLE;
         ST_SETTLE: if (settle_done)         state_d = ST_HOLD;
         ST_HOLD:   if (deliver)             state_d = ST_LOAD;
         default:                            state_d = ST_LOAD;
      endcase
   end

   // Handshake outputs depend on state only, so no comb path from in_valid/out_ready.
   always_comb begin
      in_ready  = (state_q == ST_LOAD);
      out_valid = (state_q == ST_HOLD);
      busy      = (state_q == ST_SETTLE) || (state_q == ST_HOLD);
   end

   always_comb begin
      cnt_d = cnt_q;
      set_d = set_q;
      sum_d = sum_q;
      if (accept) begin
         if (last_beat) begin
            cnt_d = '0;
            set_d = SW'(SETTLE - 1);
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (state_q == ST_SETTLE) begin
         if (settle_done) sum_d = add_sum;
         else             set_d = set_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         set_q  <= '0;
         sum_q  <= '0;
         opnd_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         set_q <= set_d;
         sum_q <= sum_d;
         if (accept) opnd_q[cnt_q] <= in_data;
      end
   end

   assign add_opnd = opnd_q;
   assign out_sum  = sum_q;

endmodule
